imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory read by the instruction fetch unit. It accepts a byte stream over a valid/ready handshake and assembles little-endian 16-bit instruction words. It writes those words to consecutive instruction-memory addresses starting at 0. Fetch is held off via `ifu_en` until the whole program has landed in memory.

## Interface

Parameters:
- `ADDR_W`, default 8: instruction-memory address width. Capacity `DEPTH = 2**ADDR_W` words.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `start`  in  1  level sampled per cycle; begins a load from IDLE, DONE or ERR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  16  write data.
- `word_cnt`  out  16  words written in the current load.
- `ifu_en`  out  1  fetch enable to the IFU; high only in DONE.
- `done`  out  1  load completed successfully; high only in DONE.
- `err`  out  1  declared length exceeds `DEPTH`; high only in ERR.

## Operation

- **Stream format:**
  - Length low byte, then length high byte. Length `L` is 16-bit, in words.
  - Then `L` words, each sent low byte first.
- **Byte acceptance:** a byte is accepted on a rising edge where `in_valid & in_ready` is 1.
- **`in_ready`:** combinational from state. It is 1 in LEN_LO, LEN_HI, DATA_LO and DATA_HI, and 0 elsewhere.
- **FSM states:** IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, DRAIN, DONE, ERR.
- **IDLE:**
  - `start` = 1 → LEN_LO.
- **LEN_LO:**
  - On accept, latch length[7:0] → LEN_HI.
- **LEN_HI:**
  - On accept, form `L`.
  - `L` = 0 → DONE.
  - `L` > `DEPTH` → ERR.
  - Otherwise → DATA_LO, and clear `word_cnt`.
- **DATA_LO:**
  - On accept, latch the low byte → DATA_HI.
- **DATA_HI, on accept, registered at the same edge:**
  - `mem_we` = 1.
  - `mem_addr` = `word_cnt[ADDR_W-1:0]`.
  - `mem_wdata` = {`in_data`, low byte}.
  - `word_cnt` increments.
  - Next state: if `word_cnt + 1 == L` → DRAIN, else → DATA_LO.
- **`mem_we` deassertion:** `mem_we` returns to 0 on the following edge unless another write is registered. Back-to-back writes are at most every 2 cycles because each word is two bytes.
- **DRAIN:** no byte accepted; unconditionally → DONE on the next edge.
- **DONE:**
  - `ifu_en` = 1, `done` = 1.
  - `start` = 1 → LEN_LO; `ifu_en` and `done` drop on that edge.
- **ERR:**
  - `err` = 1, no writes, `ifu_en` = 0.
  - `start` = 1 → LEN_LO.
- **`start` outside IDLE/DONE/ERR:** ignored.
- **Held `mem_addr` / `mem_wdata`:** they keep their last values when `mem_we` = 0.
- **Memory contents:** never cleared by this block. A partial load leaves earlier words intact.
- **Length boundary:** `L == DEPTH` is legal and fills the memory exactly. `L == DEPTH + 1` gives ERR.

## Timing

- **Reset values:** all outputs are 0, and state is IDLE. This holds for `in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `word_cnt`, `ifu_en`, `done` and `err`.
- **Reset mid-load:** outputs go to 0 asynchronously. Any pending write strobe is dropped. After release the block waits in IDLE for `start`.
- **Start latency:** `start` sampled at edge E → `in_ready` = 1 from E until the first accept.
- **Write latency:** high-byte accept at edge T → `mem_we` = 1 during cycle T..T+1.
- **Completion latency:** final high byte accepted at edge T:
  - Final `mem_we` is in cycle T..T+1 (DRAIN).
  - `done` and `ifu_en` rise at edge T+1.
  - The IFU therefore never sees `ifu_en` before the last word is written.
- **Zero length:** `L` = 0 high byte accepted at edge T → `done` rises at edge T, with no `mem_we`.
- **Upstream bubbles:** `in_valid` gaps of any length are legal. State holds until the next accept.

## Test plan

- **Basic load:** reset, `start`, stream 03 00 | 03 00 | 07 00 | 0F 00.
  - Writes in order: addr 0 = 3, addr 1 = 7, addr 2 = 15, each `mem_we` exactly one cycle.
  - `done` and `ifu_en` rise one cycle after the last `mem_we`.
  - `word_cnt` = 3.
- **Zero length:** `start`, stream 00 00 → `done` = 1, `ifu_en` = 1, `mem_we` never asserted, `word_cnt` = 0.
- **Length limits (`ADDR_W` = 8):**
  - Length 0x0101 (257): `err` = 1, `ifu_en` = 0, no writes, `in_ready` = 0.
  - Then `start`, then length 0x0100 with 256 words: writes to addrs 0..255, then `done`.
- **Backpressure:** random 0–5 cycle `in_valid` gaps during the basic-load stream → identical write sequence and values, and no byte is lost or duplicated.
- **Reset mid-load:** assert `reset` between the low and high byte of word 1.
  - All outputs are 0 immediately, with no `mem_we` for word 1.
  - A fresh `start` plus the full basic-load stream then completes correctly.
- **Reload:** in DONE, assert `start`.
  - `ifu_en` and `done` go to 0 on the next edge.
  - A new stream 01 00 | FF 00 writes addr 0 = 255, then `done` is reasserted.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed little-endian byte stream into 16-bit
// words, writes them to instruction memory from address 0, then enables fetch.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [15:0]       word_cnt,
    output logic              ifu_en,
    output logic              done,
    output logic              err
);
    localparam logic [31:0] DEPTH   = 32'd1 << ADDR_W;
    localparam logic [2:0]  IDLE    = 3'd0;
    localparam logic [2:0]  LEN_LO  = 3'd1;
    localparam logic [2:0]  LEN_HI  = 3'd2;
    localparam logic [2:0]  DATA_LO = 3'd3;
    localparam logic [2:0]  DATA_HI = 3'd4;
    localparam logic [2:0]  DRAIN   = 3'd5;
    localparam logic [2:0]  DONE    = 3'd6;
    localparam logic [2:0]  ERR     = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        lo_q, lo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              acc;
    logic [15:0]       len_full;

    assign in_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA_LO) || (state_q == DATA_HI);
    assign acc       = in_valid & in_ready;
    assign len_full  = {in_data, len_q[7:0]};
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign word_cnt  = cnt_q;
    assign ifu_en    = state_q == DONE;
    assign done      = state_q == DONE;
    assign err       = state_q == ERR;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE, ERR: state_d = start ? LEN_LO : state_q;
            LEN_LO: if (acc) begin
                len_d   = {8'h00, in_data};
                state_d = LEN_HI;
            end
            LEN_HI: if (acc) begin
                len_d   = len_full;
                cnt_d   = 16'd0;
                state_d = (len_full == 16'd0) ? DONE :
                          (32'(len_full) > DEPTH) ? ERR : DATA_LO;
            end
            DATA_LO: if (acc) begin
                lo_d    = in_data;
                state_d = DATA_HI;
            end
            DATA_HI: if (acc) begin
                we_d    = 1'b1;
                addr_d  = cnt_q[ADDR_W-1:0];
                wdata_d = {in_data, lo_q};
                cnt_d   = cnt_q + 16'd1;
                state_d = (cnt_q + 16'd1 == len_q) ? DRAIN : DATA_LO;
            end
            DRAIN: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random-stream bench comparing captured memory writes and status
// against a word-level model of the load protocol.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, ifu_en, done, err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, word_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] tb_mem[256];
    logic [15:0] model_mem[256];
    logic [7:0]  cap_addr[$];
    logic [15:0] cap_data[$];
    logic [15:0] wq[$];

    imem_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_cnt(word_cnt), .ifu_en(ifu_en), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Every cycle with the strobe high is one write into the bench's copy of memory.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wdata);
            tb_mem[mem_addr] = mem_wdata;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept: in_ready=%b required 1 for byte %h", in_ready, b);
        end else @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== model_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s memory: %0d words differ, required 0", name, bad);
        end
    endtask

    // Loads the words in wq under the declared length len, with random gaps.
    task automatic run_load(input string name, input logic [15:0] len, input int max_gap);
        logic [7:0] bytes[$];
        int n = 0;
        bit bad_len = 32'(len) > 256;
        bytes.push_back(len[7:0]);
        bytes.push_back(len[15:8]);
        if (!bad_len) foreach (wq[i]) begin
            bytes.push_back(wq[i][7:0]);
            bytes.push_back(wq[i][15:8]);
        end
        cap_addr.delete();
        cap_data.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || ifu_en !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s start: rdy=%b done=%b ifu=%b err=%b required 1 0 0 0",
                     name, in_ready, done, ifu_en, err);
        end
        foreach (bytes[i]) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(bytes[i]);
        end
        checks++;
        if (bad_len ? (err !== 1'b1 || mem_we !== 1'b0) :
            len == 16'd0 ? (done !== 1'b1 || mem_we !== 1'b0) :
                           (mem_we !== 1'b1 || done !== 1'b0)) begin
            errors++;
            $display("FAIL %s last-edge: we=%b done=%b err=%b len=%0d", name, mem_we, done, err, len);
        end
        while (done !== 1'b1 && err !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (!bad_len) foreach (wq[i]) model_mem[i] = wq[i];
        checks++;
        if (done !== !bad_len || ifu_en !== !bad_len || err !== bad_len || in_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL %s end: done=%b ifu=%b err=%b rdy=%b we=%b bad_len=%0d",
                     name, done, ifu_en, err, in_ready, mem_we, bad_len);
        end
        checks++;
        if (cap_addr.size() != (bad_len ? 0 : int'(len))) begin
            errors++;
            $display("FAIL %s write count: got %0d required %0d", name, cap_addr.size(), bad_len ? 0 : int'(len));
        end
        if (!bad_len) begin
            checks++;
            if (word_cnt !== len) begin
                errors++;
                $display("FAIL %s word_cnt: got %0d required %0d", name, word_cnt, len);
            end
            for (int i = 0; i < cap_addr.size() && i < wq.size(); i++) begin
                checks++;
                if (cap_addr[i] !== 8'(i) || cap_data[i] !== wq[i]) begin
                    errors++;
                    $display("FAIL %s write %0d: addr=%0d data=%h required addr=%0d data=%h",
                             name, i, cap_addr[i], cap_data[i], i, wq[i]);
                end
            end
        end
        check_mem(name);
    endtask

    task automatic basic_words();
        wq.delete();
        wq.push_back(16'd3);
        wq.push_back(16'd7);
        wq.push_back(16'd15);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, word_cnt, ifu_en, done, err} !== '0) begin
            errors++;
            $display("FAIL reset: rdy=%b we=%b addr=%h wd=%h cnt=%h ifu=%b done=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, word_cnt, ifu_en, done, err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle: rdy=%b done=%b required 0 0", in_ready, done);
        end
    endtask

    task automatic test_basic();
        basic_words();
        run_load("basic", 16'd3, 0);
    endtask

    task automatic test_zero();
        wq.delete();
        run_load("zero", 16'd0, 0);
    endtask

    task automatic test_limits();
        wq.delete();
        run_load("len257", 16'h0101, 0);
        for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
        run_load("len256", 16'h0100, 0);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 3; k++) begin
            basic_words();
            run_load("backpressure", 16'd3, 5);
        end
    endtask

    task automatic test_reset_mid();
        cap_addr.delete();
        cap_data.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h07);
        model_mem[0] = 16'd3;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, word_cnt, ifu_en, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: rdy=%b we=%b addr=%h wd=%h cnt=%h ifu=%b done=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, word_cnt, ifu_en, done, err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cap_addr.size() != 1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid idle: writes=%0d rdy=%b required 1 0", cap_addr.size(), in_ready);
        end
        check_mem("reset_mid");
        basic_words();
        run_load("after_reset", 16'd3, 2);
    endtask

    task automatic test_reload();
        checks++;
        if (done !== 1'b1 || ifu_en !== 1'b1) begin
            errors++;
            $display("FAIL reload pre: done=%b ifu=%b required 1 1", done, ifu_en);
        end
        wq.delete();
        wq.push_back(16'd255);
        run_load("reload", 16'd1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            int len = $urandom_range(1, 24);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back(16'($urandom));
            run_load("random", 16'(len), 3);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]    = 16'h0000;
            model_mem[i] = 16'h0000;
        end
        test_reset();
        test_basic();
        test_zero();
        test_limits();
        test_backpressure();
        test_reset_mid();
        test_reload();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
